// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: arbiter state type, default memory widths and the round-robin winner search.
package mem_arb_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

    // Scans ptr+8 .. ptr+1 so the nearest set bit after ptr is the last one assigned.
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
        logic [2:0] w;
        logic [2:0] idx;
        w = '0;
        for (int k = 8; k >= 1; k--) begin
            idx = 3'((int'(ptr) + k) % n);
            if (k <= n && req[idx]) w = idx;
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_arb_rr_picker.sv
// mem_arb_rr_picker: combinational winner select; holding ptr_i at N-1 yields fixed priority.
module mem_arb_rr_picker import mem_arb_pkg::*; #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] win_o,
    output logic          any_o
);

    assign win_o = IW'(rr_pick(8'(req_i), 3'(ptr_i), N));
    assign any_o = |req_i;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port memory between NUM_REQ requesters.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no RR pointer).
module mem_arbiter import mem_arb_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = mem_arb_pkg::ADDR_W,
    parameter int DATA_W  = mem_arb_pkg::DATA_W,
    parameter int RD_LAT  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         req_wr_rdn,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         rvalid,
    output logic [DATA_W-1:0]          rdata,
    output logic                       mem_en,
    output logic                       mem_wr_rdn,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_in_data,
    input  logic [DATA_W-1:0]          mem_out_data
);

    localparam int IW = $clog2(NUM_REQ);

    state_e              state_q, state_d;
    logic [IW-1:0]       w_q, w_d, win;
    logic                any;
    logic [1:0]          cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d, rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d, wdata_q, wdata_d;
    logic                en_q, en_d, wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
    logic [IW-1:0]       ptr_q, ptr_d;
`endif

    mem_arb_rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req_i (req),
`ifdef MEM_ARB_FIXED_PRIO_EN
        .ptr_i (IW'(NUM_REQ - 1)),
`else
        .ptr_i (ptr_q),
`endif
        .win_o (win),
        .any_o (any)
    );

    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        cnt_d    = cnt_q;
        gnt_d    = '0;
        rvalid_d = '0;
        rdata_d  = rdata_q;
        en_d     = 1'b0;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
        ptr_d    = ptr_q;
`endif
        if (state_q == IDLE && any) begin
            state_d = ISSUE;
            w_d     = win;
            gnt_d   = NUM_REQ'(1) << win;
            en_d    = 1'b1;
            wr_d    = req_wr_rdn[win];
            addr_d  = req_addr[win*ADDR_W +: ADDR_W];
            wdata_d = req_wdata[win*DATA_W +: DATA_W];
`ifndef MEM_ARB_FIXED_PRIO_EN
            ptr_d   = win;
`endif
        end else if (state_q == ISSUE) begin
            state_d = wr_q ? IDLE : WAIT;
            cnt_d   = 2'(RD_LAT - 1);
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q - 2'd1;
            if (cnt_q == '0) begin
                state_d  = IDLE;
                rdata_d  = mem_out_data;
                rvalid_d = NUM_REQ'(1) << w_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            w_q      <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            en_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            ptr_q    <= IW'(NUM_REQ - 1);
`endif
        end else begin
            state_q  <= state_d;
            w_q      <= w_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            en_q     <= en_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    assign gnt         = gnt_q;
    assign rvalid      = rvalid_q;
    assign rdata       = rdata_q;
    assign mem_en      = en_q;
    assign mem_wr_rdn  = wr_q;
    assign mem_addr    = addr_q;
    assign mem_in_data = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two arbiters (RD_LAT 1 and 3) with behavioural memories; a queue scoreboard
// holds expected grants and read returns, checked by a monitor on the falling edge.
module tb_mem_arbiter;

`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct { int cyc; int idx; logic w; logic [3:0] a; logic [7:0] v; } g_t;
    typedef struct { int cyc; int idx; logic [7:0] v; } r_t;

    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [3:0]  req_a[2], wr_a[2], gnt_a[2], rv_a[2], maddr_a[2];
    logic [15:0] addr_a[2];
    logic [31:0] wd_a[2];
    logic [7:0]  rd_a[2], mind_a[2], mout_a[2];
    logic        en_a[2], wrn_a[2];
    logic [7:0]  mem[2][16];
    logic [7:0]  pipe[2][3];
    g_t          gq[2][$];
    r_t          rq[2][$];
    g_t          ge;
    r_t          re;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(.NUM_REQ(4), .ADDR_W(4), .DATA_W(8), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .req(req_a[0]), .req_wr_rdn(wr_a[0]), .req_addr(addr_a[0]),
        .req_wdata(wd_a[0]), .gnt(gnt_a[0]), .rvalid(rv_a[0]), .rdata(rd_a[0]), .mem_en(en_a[0]),
        .mem_wr_rdn(wrn_a[0]), .mem_addr(maddr_a[0]), .mem_in_data(mind_a[0]), .mem_out_data(mout_a[0])
    );

    mem_arbiter #(.NUM_REQ(4), .ADDR_W(4), .DATA_W(8), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .req(req_a[1]), .req_wr_rdn(wr_a[1]), .req_addr(addr_a[1]),
        .req_wdata(wd_a[1]), .gnt(gnt_a[1]), .rvalid(rv_a[1]), .rdata(rd_a[1]), .mem_en(en_a[1]),
        .mem_wr_rdn(wrn_a[1]), .mem_addr(maddr_a[1]), .mem_in_data(mind_a[1]), .mem_out_data(mout_a[1])
    );

    // Memory 0 has one register stage, memory 1 has three.
    assign mout_a[0] = pipe[0][0];
    assign mout_a[1] = pipe[1][2];

    always @(posedge clk)
        for (int d = 0; d < 2; d++) begin
            if (en_a[d] && wrn_a[d]) mem[d][maddr_a[d]] <= mind_a[d];
            pipe[d][0] <= mem[d][maddr_a[d]];
            pipe[d][1] <= pipe[d][0];
            pipe[d][2] <= pipe[d][1];
        end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk)
        if (!rst)
            for (int d = 0; d < 2; d++) begin
                if (gnt_a[d] != '0 || en_a[d]) begin
                    if (gq[d].size() == 0)
                        check($sformatf("gnt_unexpected%0d", d), 64'({gnt_a[d], en_a[d]}), 64'(0));
                    else begin
                        ge = gq[d].pop_front();
                        check($sformatf("gnt%0d {cyc,gnt,en,wr,addr,wdata}", d),
                              64'({cyc, gnt_a[d], en_a[d], wrn_a[d], maddr_a[d], mind_a[d]}),
                              64'({ge.cyc, 4'(1) << ge.idx, 1'b1, ge.w, ge.a, ge.v}));
                    end
                end
                if (rv_a[d] != '0) begin
                    if (rq[d].size() == 0)
                        check($sformatf("rvalid_unexpected%0d", d), 64'(rv_a[d]), 64'(0));
                    else begin
                        re = rq[d].pop_front();
                        check($sformatf("rvalid%0d {cyc,rvalid,rdata}", d),
                              64'({cyc, rv_a[d], rd_a[d]}), 64'({re.cyc, 4'(1) << re.idx, re.v}));
                    end
                end
            end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set(input int d, input int i, input logic w, input logic [3:0] a, input logic [7:0] v);
        wr_a[d][i] = w;
        addr_a[d][i*4 +: 4] = a;
        wd_a[d][i*8 +: 8] = v;
    endtask

    task automatic pushg(input int d, input int c, input int i, input logic w, input logic [3:0] a, input logic [7:0] v);
        g_t e;
        e = '{c, i, w, a, v};
        gq[d].push_back(e);
    endtask

    task automatic pushr(input int d, input int c, input int i, input logic [7:0] v);
        r_t e;
        e = '{c, i, v};
        rq[d].push_back(e);
    endtask

    task automatic chk_reset(input int d);
        check($sformatf("reset_outputs%0d", d),
              64'({gnt_a[d], rv_a[d], rd_a[d], en_a[d], wrn_a[d], maddr_a[d], mind_a[d]}), 64'(0));
    endtask

    initial begin
        int c, idx;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_a[d] = '0;
            wr_a[d] = '0;
            addr_a[d] = '0;
            wd_a[d] = '0;
        end
        step(3);
        chk_reset(0);
        chk_reset(1);
        rst = 1'b0;
        // All four request writes continuously: rotation 0,1,2,3,0 every other cycle.
        c = cyc;
        for (int i = 0; i < 4; i++) set(0, i, 1'b1, 4'(8 + i), 8'(16 + i));
        req_a[0] = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            idx = FIXED ? 0 : k % 4;
            pushg(0, c + 1 + 2 * k, idx, 1'b1, 4'(8 + idx), 8'(16 + idx));
        end
        step(9);
        req_a[0] = '0;
        step(2);
        // Requester 2 writes A7 to 5, then reads it back.
        c = cyc;
        set(0, 2, 1'b1, 4'h5, 8'hA7);
        req_a[0] = 4'b0100;
        pushg(0, c + 1, 2, 1'b1, 4'h5, 8'hA7);
        step(1);
        set(0, 2, 1'b0, 4'h5, 8'h00);
        pushg(0, c + 3, 2, 1'b0, 4'h5, 8'h00);
        pushr(0, c + 5, 2, 8'hA7);
        step(2);
        req_a[0] = '0;
        step(4);
        // Pointer at 1: requester 0 beats requester 1 next.
        c = cyc;
        set(0, 1, 1'b1, 4'h1, 8'h11);
        set(0, 0, 1'b1, 4'h0, 8'h22);
        req_a[0] = 4'b0010;
        pushg(0, c + 1, 1, 1'b1, 4'h1, 8'h11);
        step(1);
        req_a[0] = 4'b0011;
        pushg(0, c + 3, 0, 1'b1, 4'h0, 8'h22);
        step(2);
        req_a[0] = 4'b0010;
        pushg(0, c + 5, 1, 1'b1, 4'h1, 8'h11);
        step(2);
        req_a[0] = '0;
        step(2);
        // Reset lands on the WAIT cycle of a read from requester 3.
        c = cyc;
        set(0, 3, 1'b0, 4'h5, 8'h33);
        req_a[0] = 4'b1000;
        pushg(0, c + 1, 3, 1'b0, 4'h5, 8'h33);
        step(1);
        req_a[0] = '0;
        step(1);
        rst = 1'b1;
        step(1);
        chk_reset(0);
        chk_reset(1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set(0, i, 1'b1, 4'(i), 8'(64 + i));
        req_a[0] = 4'b1111;
        pushg(0, c + 4, 0, 1'b1, 4'h0, 8'h40);
        step(1);
        req_a[0] = '0;
        step(2);
        // req 1001 held: round robin alternates starting at 3, fixed priority always picks 0.
        c = cyc;
        set(0, 0, 1'b1, 4'h3, 8'h55);
        set(0, 3, 1'b1, 4'hC, 8'h66);
        req_a[0] = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            idx = FIXED ? 0 : (k % 2 == 0 ? 3 : 0);
            pushg(0, c + 1 + 2 * k, idx, 1'b1, idx == 0 ? 4'h3 : 4'hC, idx == 0 ? 8'h55 : 8'h66);
        end
        step(7);
        req_a[0] = '0;
        step(2);
        // RD_LAT=3: write F, read it back while 1..3 wait through the WAIT cycles.
        c = cyc;
        set(1, 0, 1'b1, 4'hF, 8'h3C);
        for (int i = 1; i < 4; i++) set(1, i, 1'b1, 4'(i), 8'(160 + i));
        req_a[1] = 4'b0001;
        pushg(1, c + 1, 0, 1'b1, 4'hF, 8'h3C);
        step(1);
        set(1, 0, 1'b0, 4'hF, 8'h00);
        pushg(1, c + 3, 0, 1'b0, 4'hF, 8'h00);
        pushr(1, c + 7, 0, 8'h3C);
        pushg(1, c + 8, 1, 1'b1, 4'h1, 8'hA1);
        pushg(1, c + 10, 2, 1'b1, 4'h2, 8'hA2);
        pushg(1, c + 12, 3, 1'b1, 4'h3, 8'hA3);
        step(2);
        req_a[1] = 4'b1110;
        step(5);
        req_a[1] = 4'b1100;
        step(2);
        req_a[1] = 4'b1000;
        step(2);
        req_a[1] = '0;
        step(4);
        check("pending_expectations", 64'(gq[0].size() + rq[0].size() + gq[1].size() + rq[1].size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not reach the summary");
        $fatal(1);
    end

endmodule
